cdb_tx_queue: RTL and testbench

CDB_TX_QUEUE -- requirements
Module: cdb_tx_queue

---
 rtl/cdb_tx_queue_pkg.sv | 17 +
 rtl/cdb_rr_arbiter.sv | 43 ++++
 rtl/cdb_tx_queue.sv | 140 ++++++++++++++
 tb/tb_cdb_tx_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_tx_queue_pkg.sv
// Shared superscalar definitions: canonical CDB entry layout and channel tags.
package cdb_tx_queue_pkg;

  localparam int unsigned CDB_DATA_W = 32;
  localparam int unsigned CDB_PREG_W = 6;

  localparam logic [1:0] CDB_TAG_ALU0 = 2'b00;
  localparam logic [1:0] CDB_TAG_ALU1 = 2'b01;
  localparam logic [1:0] CDB_TAG_ALU2 = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [CDB_PREG_W-1:0] dest_reg;
    logic [CDB_DATA_W-1:0] data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_rr_arbiter.sv
// Two-way round-robin readiness arbiter driven by the free-entry count of the CDB queue.
module cdb_rr_arbiter #(
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          req0,
  input  logic          req1,
  input  logic [CW-1:0] free,
  output logic          ready0,
  output logic          ready1,
  output logic          first1
);

  logic rr;

  // Readiness looks only at the registered free count, never at the requests.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (!reset && !flush) begin
      if (free >= CW'(2)) begin
        ready0 = 1'b1;
        ready1 = 1'b1;
      end else if (free == CW'(1)) begin
        ready0 = !rr;
        ready1 = rr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr <= 1'b0;
    end else if (!flush && req0 && req1 && (free == CW'(1))) begin
      rr <= ~rr;
    end
  end

  assign first1 = rr;

endmodule

// File: rtl/cdb_tx_queue.sv
// Dual-producer CDB transmit queue, one broadcast per cycle, no CDB backpressure.
// Optional same-cycle bypass on an empty queue when CDB_TX_BYPASS_EN is defined.
module cdb_tx_queue
  import cdb_tx_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned PHYS_REG_ADDR_WIDTH = 6,
  parameter int unsigned DEPTH               = 4,
  parameter logic [1:0]  CHANNEL_TAG         = CDB_TAG_ALU0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           src0_valid,
  output logic                           src0_ready,
  input  logic [DATA_WIDTH-1:0]          src0_data,
  input  logic [PHYS_REG_ADDR_WIDTH-1:0] src0_dest_reg,
  input  logic                           src1_valid,
  output logic                           src1_ready,
  input  logic [DATA_WIDTH-1:0]          src1_data,
  input  logic [PHYS_REG_ADDR_WIDTH-1:0] src1_dest_reg,
  output logic                           cdb_valid,
  output logic [1:0]                     cdb_tag,
  output logic [DATA_WIDTH-1:0]          cdb_data,
  output logic [PHYS_REG_ADDR_WIDTH-1:0] cdb_dest_reg,
  output logic [$clog2(DEPTH):0]         occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = PHYS_REG_ADDR_WIDTH + DATA_WIDTH;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, free;
  logic          ready0, ready1, first1;
  logic          acc0, acc1, pop, bypass_hit;
  logic [1:0]    n_acc, n_push;
  logic [EW-1:0] ent0, ent1, first_ent, second_ent, store0, head_ent;

  assign free = CW'(DEPTH) - count;

  cdb_rr_arbiter #(
    .CW (CW)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .req0   (src0_valid),
    .req1   (src1_valid),
    .free   (free),
    .ready0 (ready0),
    .ready1 (ready1),
    .first1 (first1)
  );

  assign src0_ready = ready0;
  assign src1_ready = ready1;
  assign acc0       = src0_valid & ready0;
  assign acc1       = src1_valid & ready1;
  assign ent0       = {src0_dest_reg, src0_data};
  assign ent1       = {src1_dest_reg, src1_data};

  // Put the accepted entries in arrival order: the rr-named source is older.
  always_comb begin
    n_acc      = 2'd0;
    first_ent  = ent0;
    second_ent = ent1;
    if (acc0 && acc1) begin
      n_acc = 2'd2;
      if (first1) begin
        first_ent  = ent1;
        second_ent = ent0;
      end
    end else if (acc1) begin
      n_acc     = 2'd1;
      first_ent = ent1;
    end else if (acc0) begin
      n_acc = 2'd1;
    end
  end

`ifdef CDB_TX_BYPASS_EN
  assign bypass_hit = (count == '0) && !flush && (acc0 || acc1);
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed entry goes straight to the CDB, so only the younger one is stored.
  assign store0 = bypass_hit ? second_ent : first_ent;
  assign n_push = n_acc - {1'b0, bypass_hit};
  assign pop    = (count != '0);

  always_ff @(posedge clk) begin
    if (!flush && (n_push != 2'd0)) begin
      mem[wr_ptr] <= store0;
    end
    if (!flush && (n_push == 2'd2)) begin
      mem[wr_ptr + AW'(1)] <= second_ent;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(n_push);
      count  <= count + CW'(n_push) - CW'(pop);
    end
  end

  assign head_ent  = mem[rd_ptr];
  assign occupancy = count;

  always_comb begin
    cdb_valid    = 1'b0;
    cdb_tag      = '0;
    cdb_data     = '0;
    cdb_dest_reg = '0;
    if (!flush) begin
      if (pop) begin
        cdb_valid                = 1'b1;
        cdb_tag                  = CHANNEL_TAG;
        {cdb_dest_reg, cdb_data} = head_ent;
      end else if (bypass_hit) begin
        cdb_valid                = 1'b1;
        cdb_tag                  = CHANNEL_TAG;
        {cdb_dest_reg, cdb_data} = first_ent;
      end
    end
  end

endmodule

// File: tb/tb_cdb_tx_queue.sv
// Self-checking bench for cdb_tx_queue: queue-based reference model plus directed literal checks.
module tb_cdb_tx_queue;
  import cdb_tx_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [1:0] TAG = CDB_TAG_ALU2;
`ifdef CDB_TX_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        src0_valid, src0_ready, src1_valid, src1_ready;
  logic [31:0] src0_data, src1_data, cdb_data;
  logic [5:0]  src0_dest_reg, src1_dest_reg, cdb_dest_reg;
  logic        cdb_valid;
  logic [1:0]  cdb_tag;
  logic [2:0]  occupancy;

  cdb_tx_queue #(
    .DATA_WIDTH          (32),
    .PHYS_REG_ADDR_WIDTH (6),
    .DEPTH               (DEPTH),
    .CHANNEL_TAG         (TAG)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .src0_valid    (src0_valid),
    .src0_ready    (src0_ready),
    .src0_data     (src0_data),
    .src0_dest_reg (src0_dest_reg),
    .src1_valid    (src1_valid),
    .src1_ready    (src1_ready),
    .src1_data     (src1_data),
    .src1_dest_reg (src1_dest_reg),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .cdb_dest_reg  (cdb_dest_reg),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  cdb_entry_t mq[$];
  cdb_entry_t bc_log[$];
  bit         m_rr = 1'b0;

  logic        s_valid, s_r0, s_r1;
  logic [1:0]  s_tag;
  logic [31:0] s_data;
  logic [5:0]  s_dest;
  logic [2:0]  s_occ;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare DUT against the model, then advance the model.
  task automatic step(input bit f,
                      input bit v0, input logic [31:0] d0, input logic [5:0] r0,
                      input bit v1, input logic [31:0] d1, input logic [5:0] r1,
                      output bit a0, output bit a1);
    cdb_entry_t arr[$];
    cdb_entry_t e0, e1, expb;
    int free;
    bit er0, er1, ev;
    @(negedge clk);
    flush = f;
    src0_valid = v0; src0_data = d0; src0_dest_reg = r0;
    src1_valid = v1; src1_data = d1; src1_dest_reg = r1;
    #1;
    free = DEPTH - mq.size();
    er0 = 1'b0; er1 = 1'b0;
    if (!f) begin
      if (free >= 2) begin er0 = 1'b1; er1 = 1'b1; end
      else if (free == 1) begin er0 = !m_rr; er1 = m_rr; end
    end
    a0 = v0 && er0;
    a1 = v1 && er1;
    e0 = '{valid: 1'b1, dest_reg: r0, data: d0};
    e1 = '{valid: 1'b1, dest_reg: r1, data: d1};
    if (a0 && a1) begin
      if (m_rr) begin arr.push_back(e1); arr.push_back(e0); end
      else begin arr.push_back(e0); arr.push_back(e1); end
    end else if (a0) arr.push_back(e0);
    else if (a1) arr.push_back(e1);
    ev = 1'b0; expb = '0;
    if (!f) begin
      if (mq.size() > 0) begin ev = 1'b1; expb = mq[0]; end
      else if (BYPASS && arr.size() > 0) begin ev = 1'b1; expb = arr[0]; end
    end
    s_valid = cdb_valid; s_tag = cdb_tag; s_data = cdb_data; s_dest = cdb_dest_reg;
    s_occ = occupancy; s_r0 = src0_ready; s_r1 = src1_ready;
    chk("src0_ready", s_r0, er0);
    chk("src1_ready", s_r1, er1);
    chk("cdb_valid", s_valid, ev);
    chk("cdb_tag", s_tag, ev ? TAG : 2'b00);
    chk("cdb_data", s_data, ev ? expb.data : 32'h0);
    chk("cdb_dest_reg", s_dest, ev ? expb.dest_reg : 6'h0);
    chk("occupancy", s_occ, mq.size());
    if (ev) bc_log.push_back(expb);
    @(posedge clk);
    if (f) mq.delete();
    else begin
      if (mq.size() > 0) void'(mq.pop_front());
      else if (BYPASS && arr.size() > 0) void'(arr.pop_front());
      foreach (arr[i]) mq.push_back(arr[i]);
    end
    if (!f && v0 && v1 && free == 1) m_rr = !m_rr;
  endtask

  task automatic idle(input int n);
    bit x0, x1;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 6'h0, x0, x1);
  endtask

  initial begin
    bit a0, a1, p0, p1, f;
    logic [31:0] d0, d1;
    logic [5:0]  r0, r1;
    int na, nb, nf;

    reset = 1'b1; flush = 1'b0;
    src0_valid = 1'b0; src0_data = '0; src0_dest_reg = '0;
    src1_valid = 1'b0; src1_data = '0; src1_dest_reg = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", src0_ready, 1'b0);
    chk("rst_ready1", src1_ready, 1'b0);
    chk("rst_valid", cdb_valid, 1'b0);
    chk("rst_occ", occupancy, 3'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single push latency
    step(1'b0, 1'b1, 32'h1234, 6'd5, 1'b0, 32'h0, 6'h0, a0, a1);
    chk("single_accept", a0, 1'b1);
`ifdef CDB_TX_BYPASS_EN
    chk("bypass_valid", s_valid, 1'b1);
    chk("bypass_data", s_data, 32'h1234);
    idle(1);
`else
    chk("lat_same_cycle_valid", s_valid, 1'b0);
    idle(1);
    chk("lat_valid", s_valid, 1'b1);
    chk("lat_tag", s_tag, TAG);
    chk("lat_data", s_data, 32'h1234);
    chk("lat_dest", s_dest, 6'd5);
`endif
    idle(2);

    // Dual-source burst: 4 results from each source
    bc_log.delete();
    na = 0; nb = 0;
    for (int c = 0; c < 20 && (na < 4 || nb < 4); c++) begin
      step(1'b0, na < 4, 32'hA0 + 32'(na), 6'(na + 1), nb < 4, 32'hB0 + 32'(nb), 6'(nb + 9), a0, a1);
`ifndef CDB_TX_BYPASS_EN
      if (c == 2) begin
        chk("throttle_c2_r0", s_r0, 1'b1); chk("throttle_c2_r1", s_r1, 1'b0);
        chk("grant_c2", {a0, a1}, 2'b10);
      end
      if (c == 3) begin
        chk("throttle_c3_r0", s_r0, 1'b0); chk("throttle_c3_r1", s_r1, 1'b1);
        chk("grant_c3", {a0, a1}, 2'b01);
      end
`endif
      if (a0) na++;
      if (a1) nb++;
    end
    chk("burst_accepted", na + nb, 8);
    idle(6);
    chk("burst_bc_count", bc_log.size(), 8);
    for (int i = 0; i < 8 && i < bc_log.size(); i++)
      chk("burst_order", bc_log[i].data, (i % 2 == 0) ? 32'hA0 + 32'(i / 2) : 32'hB0 + 32'(i / 2));

    // Flush with a queue of three
    bc_log.delete();
    step(1'b0, 1'b1, 32'h11, 6'd1, 1'b1, 32'h12, 6'd2, a0, a1);
    step(1'b0, 1'b1, 32'h13, 6'd3, 1'b1, 32'h14, 6'd4, a0, a1);
    step(1'b1, 1'b1, 32'hF1, 6'd7, 1'b0, 32'h0, 6'h0, a0, a1);
`ifndef CDB_TX_BYPASS_EN
    chk("flush_pre_occ", s_occ, 3'd3);
`endif
    chk("flush_valid", s_valid, 1'b0);
    chk("flush_ready0", s_r0, 1'b0);
    idle(1);
    chk("flush_occ_after", s_occ, 3'd0);
    chk("flush_valid_after", s_valid, 1'b0);
    idle(3);
    nf = 0;
    foreach (bc_log[i]) if (bc_log[i].data == 32'hF1) nf++;
    chk("flush_push_dropped", nf, 0);

    // Pointer wrap: ten sequential single pushes
    bc_log.delete();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'(i), 6'(i), 1'b0, 32'h0, 6'h0, a0, a1);
    idle(3);
    chk("wrap_count", bc_log.size(), 10);
    for (int i = 0; i < 10 && i < bc_log.size(); i++) chk("wrap_order", bc_log[i].data, 32'(i));

    // Randomized traffic with held sources and occasional flush
    p0 = 1'b0; p1 = 1'b0; d0 = '0; d1 = '0; r0 = '0; r1 = '0;
    for (int c = 0; c < 1500; c++) begin
      int lvl;
      lvl = ((c / 150) % 2 == 1) ? 7 : 3;
      if (!p0 && $urandom_range(7) < lvl) begin p0 = 1'b1; d0 = $urandom; r0 = 6'($urandom); end
      if (!p1 && $urandom_range(7) < lvl) begin p1 = 1'b1; d1 = $urandom; r1 = 6'($urandom); end
      f = ($urandom_range(24) == 0);
      step(f, p0, d0, r0, p1, d1, r1, a0, a1);
      if (a0) p0 = 1'b0;
      if (a1) p1 = 1'b0;
    end
    idle(5);

    // Asynchronous reset between edges with entries queued
    step(1'b0, 1'b1, 32'hC0, 6'd1, 1'b1, 32'hC1, 6'd2, a0, a1);
    #2;
    src0_valid = 1'b0; src1_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", cdb_valid, 1'b0);
    chk("async_rst_tag", cdb_tag, 2'b00);
    chk("async_rst_data", cdb_data, 32'h0);
    chk("async_rst_dest", cdb_dest_reg, 6'h0);
    chk("async_rst_occ", occupancy, 3'd0);
    chk("async_rst_ready0", src0_ready, 1'b0);
    chk("async_rst_ready1", src1_ready, 1'b0);
    mq.delete();
    m_rr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bc_log.delete();
    idle(4);
    chk("post_reset_bc", bc_log.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
